// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the integer register file write-back path.
package regfile_pkg;

  localparam int unsigned REG_WIDTH_DEF = 32;
  localparam int unsigned NUM_REGS_DEF  = 32;
  localparam int unsigned ADDR_W_DEF    = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // Bit positions of the ALU/LSU requesters in the arbiter request/grant vectors.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// Write-back bundle: ALU/LSU results, issue/hazard-check port and register file write port.
// Optional forwarding outputs are present when WB_BYPASS_EN is defined.
interface regfile_writeback_if #(
  parameter int unsigned REG_WIDTH = regfile_pkg::REG_WIDTH_DEF,
  parameter int unsigned NUM_REGS  = regfile_pkg::NUM_REGS_DEF
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic                 alu_valid;
  logic                 alu_ready;
  logic [ADDR_W-1:0]    alu_rd;
  logic [REG_WIDTH-1:0] alu_data;
  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [ADDR_W-1:0]    lsu_rd;
  logic [REG_WIDTH-1:0] lsu_data;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [ADDR_W-1:0]    issue_rd;
  logic [ADDR_W-1:0]    chk_rs1;
  logic [ADDR_W-1:0]    chk_rs2;
  logic                 chk_rs1_busy;
  logic                 chk_rs2_busy;
  logic                 wrEn;
  logic [ADDR_W-1:0]    wrAddr;
  logic [REG_WIDTH-1:0] wrData;
  logic                 sb_err;
`ifdef WB_BYPASS_EN
  logic                 byp_rs1_hit;
  logic                 byp_rs2_hit;
  logic [REG_WIDTH-1:0] byp_data;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  alu_ready, lsu_ready, issue_ready, chk_rs1_busy, chk_rs2_busy,
           wrEn, wrAddr, wrData, sb_err, byp_rs1_hit, byp_rs2_hit, byp_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, chk_rs1, chk_rs2,
    output alu_ready, lsu_ready, issue_ready, chk_rs1_busy, chk_rs2_busy,
           wrEn, wrAddr, wrData, sb_err, byp_rs1_hit, byp_rs2_hit, byp_data
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, chk_rs1, chk_rs2,
    input  alu_ready, lsu_ready, issue_ready, chk_rs1_busy, chk_rs2_busy,
           wrEn, wrAddr, wrData, sb_err
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, chk_rs1, chk_rs2,
    output alu_ready, lsu_ready, issue_ready, chk_rs1_busy, chk_rs2_busy,
           wrEn, wrAddr, wrData, sb_err
  );
`endif

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter (bit 0 = ALU, bit 1 = LSU); the pointer only
// moves when both sides request, handing priority to the loser.
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e ptr_q, ptr_d;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    gnt   = 2'b00;
    ptr_d = ptr_q;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (ptr_q == WB_SRC_LSU) begin
          gnt   = 2'b10;
          ptr_d = WB_SRC_ALU;
        end else begin
          gnt   = 2'b01;
          ptr_d = WB_SRC_LSU;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= WB_SRC_LSU;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register file write-side front end: ALU/LSU arbitration, registered write port and
// per-register pending-write scoreboard. Define WB_BYPASS_EN for early commit plus forwarding.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int unsigned REG_WIDTH = REG_WIDTH_DEF,
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned PEND_W    = 2
)(
  input logic clk,
  input logic rst,
  regfile_writeback_if.slave wb
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [1:0]           gnt;
  logic                 xfer;
  logic [ADDR_W-1:0]    xfer_rd;
  logic [REG_WIDTH-1:0] xfer_data;

  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [REG_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 sb_err_q, sb_err_d;
  logic [PEND_W-1:0]    pend_q [NUM_REGS];
  logic [PEND_W-1:0]    pend_d [NUM_REGS];

  logic                 issue_fire;
  logic                 commit_vld;
  logic [ADDR_W-1:0]    commit_rd;
  logic [NUM_REGS-1:0]  inc_vec, dec_vec;

  wb_rr_arbiter u_arb (
    .clk (clk),
    .rst (rst),
    .req ({wb.lsu_valid, wb.alu_valid}),
    .gnt (gnt)
  );

  assign wb.alu_ready = gnt[0];
  assign wb.lsu_ready = gnt[1];

  // A grant is only ever given to a valid requester, so any grant is a transfer.
  always_comb begin
    xfer      = |gnt;
    xfer_rd   = gnt[1] ? wb.lsu_rd   : wb.alu_rd;
    xfer_data = gnt[1] ? wb.lsu_data : wb.alu_data;
    wr_en_d   = xfer && (xfer_rd != '0);
    wr_addr_d = wr_en_d ? xfer_rd   : wr_addr_q;
    wr_data_d = wr_en_d ? xfer_data : wr_data_q;
  end

  assign wb.issue_ready = (wb.issue_rd == '0) || (pend_q[wb.issue_rd] != PEND_MAX);
  assign issue_fire     = wb.issue_valid && wb.issue_ready && (wb.issue_rd != '0);

`ifdef WB_BYPASS_EN
  assign commit_vld     = wr_en_d;
  assign commit_rd      = xfer_rd;
  assign wb.byp_rs1_hit = wr_en_q && (wr_addr_q == wb.chk_rs1) && (wb.chk_rs1 != '0);
  assign wb.byp_rs2_hit = wr_en_q && (wr_addr_q == wb.chk_rs2) && (wb.chk_rs2 != '0);
  assign wb.byp_data    = wr_data_q;
`else
  assign commit_vld = wr_en_q;
  assign commit_rd  = wr_addr_q;
`endif

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_fire) inc_vec[wb.issue_rd] = 1'b1;
    if (commit_vld) dec_vec[commit_rd]   = 1'b1;
  end

  // Simultaneous issue and commit to one register cancel out.
  always_comb begin
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      unique case ({inc_vec[r], dec_vec[r]})
        2'b10: pend_d[r] = pend_q[r] + PEND_W'(1);
        2'b01: begin
          if (pend_q[r] != '0) pend_d[r] = pend_q[r] - PEND_W'(1);
          else                 sb_err_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wb.chk_rs1_busy = (wb.chk_rs1 != '0) && (pend_q[wb.chk_rs1] != '0);
  assign wb.chk_rs2_busy = (wb.chk_rs2 != '0) && (pend_q[wb.chk_rs2] != '0);

  assign wb.wrEn   = wr_en_q;
  assign wb.wrAddr = wr_addr_q;
  assign wb.wrData = wr_data_q;
  assign wb.sb_err = sb_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sb_err_q  <= 1'b0;
      // NOTE: this small counter array must clear on reset (hazard state), unlike a data RAM.
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sb_err_q  <= sb_err_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback (default build): vector table plus hand-written
// saturation, same-cycle issue/commit and asynchronous reset sequences.
module tb_regfile_writeback;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  regfile_writeback_if #(.REG_WIDTH(32), .NUM_REGS(32)) wb ();

  regfile_writeback #(.REG_WIDTH(32), .NUM_REGS(32), .PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_d;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  e_rdy;   // {alu_ready, lsu_ready, issue_ready} before the edge
    logic [1:0]  e_busy;  // {chk_rs1_busy, chk_rs2_busy} before the edge
    logic        e_wen;   // after the edge
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input int av, input int ard, input int ad,
                              input int lv, input int lrd, input int ld,
                              input int iv, input int ird, input int r1, input int r2,
                              input int rdy, input int busy,
                              input int wen, input int waddr, input int wdata, input int err);
    vec_t v;
    v.alu_v   = av[0];   v.alu_rd  = ard[4:0];  v.alu_d   = ad;
    v.lsu_v   = lv[0];   v.lsu_rd  = lrd[4:0];  v.lsu_d   = ld;
    v.iss_v   = iv[0];   v.iss_rd  = ird[4:0];
    v.rs1     = r1[4:0]; v.rs2     = r2[4:0];
    v.e_rdy   = rdy[2:0];
    v.e_busy  = busy[1:0];
    v.e_wen   = wen[0];  v.e_waddr = waddr[4:0]; v.e_wdata = wdata;
    v.e_err   = err[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
    wb.issue_valid = 1'b0; wb.issue_rd = '0;
    wb.chk_rs1 = '0; wb.chk_rs2 = '0;
  endtask

  task automatic alu_put(input logic [4:0] rd, input logic [31:0] data);
    wb.alu_valid = 1'b1; wb.alu_rd = rd; wb.alu_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1);
  end

  initial begin
    //          alu v,rd,data       lsu v,rd,data        iss v,rd rs1,rs2 rdy    busy  wen,addr,data         err
    vecs[0]  = mk(0,0,0,            0,0,0,               1,5, 5,0, 'b001,'b00, 0,0,0,                 0);
    vecs[1]  = mk(1,5,'hDEADBEEF,   0,0,0,               0,0, 5,0, 'b101,'b10, 1,5,'hDEADBEEF,        0);
    vecs[2]  = mk(0,0,0,            0,0,0,               0,0, 5,0, 'b001,'b10, 0,5,'hDEADBEEF,        0);
    vecs[3]  = mk(0,0,0,            0,0,0,               0,0, 5,0, 'b001,'b00, 0,5,'hDEADBEEF,        0);
    vecs[4]  = mk(0,0,0,            0,0,0,               1,1, 1,2, 'b001,'b00, 0,5,'hDEADBEEF,        0);
    vecs[5]  = mk(0,0,0,            0,0,0,               1,1, 1,2, 'b001,'b10, 0,5,'hDEADBEEF,        0);
    vecs[6]  = mk(0,0,0,            0,0,0,               1,2, 1,2, 'b001,'b10, 0,5,'hDEADBEEF,        0);
    vecs[7]  = mk(0,0,0,            0,0,0,               1,2, 1,2, 'b001,'b11, 0,5,'hDEADBEEF,        0);
    vecs[8]  = mk(1,1,'h11,         1,2,'h22,            0,0, 1,2, 'b011,'b11, 1,2,'h22,              0);
    vecs[9]  = mk(1,1,'h11,         1,2,'h23,            0,0, 1,2, 'b101,'b11, 1,1,'h11,              0);
    vecs[10] = mk(1,1,'h12,         1,2,'h23,            0,0, 1,2, 'b011,'b11, 1,2,'h23,              0);
    vecs[11] = mk(1,1,'h12,         1,2,'h24,            0,0, 1,2, 'b101,'b11, 1,1,'h12,              0);
    vecs[12] = mk(0,0,0,            0,0,0,               0,0, 1,2, 'b001,'b10, 0,1,'h12,              0);
    vecs[13] = mk(0,0,0,            0,0,0,               1,0, 1,0, 'b001,'b00, 0,1,'h12,              0);
    vecs[14] = mk(0,0,0,            1,0,'h1234,          0,0, 0,0, 'b011,'b00, 0,1,'h12,              0);
    vecs[15] = mk(1,9,'h99,         0,0,0,               0,0, 9,0, 'b101,'b00, 1,9,'h99,              0);
    vecs[16] = mk(0,0,0,            0,0,0,               0,0, 9,0, 'b001,'b00, 0,9,'h99,              1);
    vecs[17] = mk(0,0,0,            0,0,0,               0,0, 9,0, 'b001,'b00, 0,9,'h99,              1);
    vecs[18] = mk(1,3,'h33,         1,4,'h44,            0,0, 0,0, 'b011,'b00, 1,4,'h44,              1);

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset wrEn",   {31'b0, wb.wrEn}, 32'd0);
    check("reset wrAddr", {27'b0, wb.wrAddr}, 32'd0);
    check("reset wrData", wb.wrData, 32'd0);
    check("reset sb_err", {31'b0, wb.sb_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      wb.alu_valid = vecs[i].alu_v; wb.alu_rd = vecs[i].alu_rd; wb.alu_data = vecs[i].alu_d;
      wb.lsu_valid = vecs[i].lsu_v; wb.lsu_rd = vecs[i].lsu_rd; wb.lsu_data = vecs[i].lsu_d;
      wb.issue_valid = vecs[i].iss_v; wb.issue_rd = vecs[i].iss_rd;
      wb.chk_rs1 = vecs[i].rs1; wb.chk_rs2 = vecs[i].rs2;
      #1;
      check($sformatf("v%0d ready{alu,lsu,iss}", i),
            {29'b0, wb.alu_ready, wb.lsu_ready, wb.issue_ready}, {29'b0, vecs[i].e_rdy});
      check($sformatf("v%0d busy{rs1,rs2}", i),
            {30'b0, wb.chk_rs1_busy, wb.chk_rs2_busy}, {30'b0, vecs[i].e_busy});
      tick();
      check($sformatf("v%0d wrEn", i),   {31'b0, wb.wrEn},   {31'b0, vecs[i].e_wen});
      check($sformatf("v%0d wrAddr", i), {27'b0, wb.wrAddr}, {27'b0, vecs[i].e_waddr});
      check($sformatf("v%0d wrData", i), wb.wrData, vecs[i].e_wdata);
      check($sformatf("v%0d sb_err", i), {31'b0, wb.sb_err}, {31'b0, vecs[i].e_err});
    end

    // rd=7: three issues saturate the 2-bit counter, a fourth is refused.
    idle();
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd7; wb.chk_rs1 = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("rd7 issue%0d ready", k), {31'b0, wb.issue_ready}, 32'd1);
      tick();
    end
    #1;
    check("rd7 saturated issue_ready", {31'b0, wb.issue_ready}, 32'd0);
    check("rd7 saturated busy", {31'b0, wb.chk_rs1_busy}, 32'd1);
    tick();
    wb.issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      alu_put(5'd7, 32'h70 + k);
      #1;
      check($sformatf("rd7 write%0d alu_ready", k), {31'b0, wb.alu_ready}, 32'd1);
      tick();
      check($sformatf("rd7 write%0d wrAddr", k), {27'b0, wb.wrAddr}, 32'd7);
      check($sformatf("rd7 write%0d wrData", k), wb.wrData, 32'h70 + k);
    end
    wb.alu_valid = 1'b0;
    #1;
    check("rd7 busy before last commit", {31'b0, wb.chk_rs1_busy}, 32'd1);
    tick();
    check("rd7 busy after last commit", {31'b0, wb.chk_rs1_busy}, 32'd0);
    check("rd7 wrEn drops", {31'b0, wb.wrEn}, 32'd0);

    // rd=3: issue and commit land on the same edge, counter must stay at 1.
    idle();
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd3;
    tick();
    wb.issue_valid = 1'b0;
    alu_put(5'd3, 32'h30);
    tick();
    wb.alu_valid = 1'b0;
    wb.issue_valid = 1'b1;
    #1;
    check("rd3 same-cycle issue_ready", {31'b0, wb.issue_ready}, 32'd1);
    tick();
    idle();
    wb.chk_rs1 = 5'd3;
    #1;
    check("rd3 busy after issue+commit", {31'b0, wb.chk_rs1_busy}, 32'd1);
    tick();
    check("rd3 busy one cycle later", {31'b0, wb.chk_rs1_busy}, 32'd1);
    alu_put(5'd3, 32'h31);
    tick();
    wb.alu_valid = 1'b0;
    tick();
    check("rd3 busy after final commit", {31'b0, wb.chk_rs1_busy}, 32'd0);

    // Asynchronous reset while a write and a pending issue are in flight.
    idle();
    wb.issue_valid = 1'b1; wb.issue_rd = 5'd10;
    alu_put(5'd11, 32'hAB);
    tick();
    idle();
    wb.chk_rs1 = 5'd10; wb.chk_rs2 = 5'd11;
    #1;
    check("pre-reset wrEn", {31'b0, wb.wrEn}, 32'd1);
    check("pre-reset rs1 busy", {31'b0, wb.chk_rs1_busy}, 32'd1);
    check("pre-reset sb_err", {31'b0, wb.sb_err}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset wrEn", {31'b0, wb.wrEn}, 32'd0);
    check("async reset wrAddr", {27'b0, wb.wrAddr}, 32'd0);
    check("async reset wrData", wb.wrData, 32'd0);
    check("async reset rs1 busy", {31'b0, wb.chk_rs1_busy}, 32'd0);
    check("async reset sb_err", {31'b0, wb.sb_err}, 32'd0);
    #2 rst = 1'b0;
    tick();
    check("post-reset wrEn dropped", {31'b0, wb.wrEn}, 32'd0);
    check("post-reset sb_err", {31'b0, wb.sb_err}, 32'd0);
    alu_put(5'd5, 32'h55);
    #1;
    check("post-reset alu_ready", {31'b0, wb.alu_ready}, 32'd1);
    tick();
    check("post-reset wrEn", {31'b0, wb.wrEn}, 32'd1);
    check("post-reset wrAddr", {27'b0, wb.wrAddr}, 32'd5);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
